if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline.
- Holds the program counter and computes the next PC: sequential +4 or the branch/jump target from Execute.
- Drives the instruction-memory address.
- Captures fetched instruction, PC and PC+4 into the IF/ID pipeline register.
- Supports stall and flush from the hazard unit, and traps on misaligned redirect targets.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/if_id_reg.sv | 37 +++
 rtl/if_stage.sv | 85 ++++++++
 tb/tb_if_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, reset PC, bubble encoding, fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying instruction, PC and PC+4 plus a valid bit, with stall and flush.
// Flush has priority over stall so a squashed slot never survives a hold.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned     W            = 32,
  parameter logic [W-1:0]    BUBBLE_INSTR = W'(riscv_pkg::NOP_INSTR)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] instr_src,
  input  logic [W-1:0] pc_src,
  input  logic [W-1:0] pcplus4_src,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc,
  output logic [W-1:0] pcplus4,
  output logic         valid
);

  // Bubble on reset or flush, hold on stall, otherwise capture the upstream stage.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr   <= BUBBLE_INSTR;
      pc      <= '0;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (!stall) begin
      instr   <= instr_src;
      pc      <= pc_src;
      pcplus4 <= pcplus4_src;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, misaligned-target trap and IF/ID register.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        Trap,
  output logic [31:0] TrapAddr
);

  fetch_state_t state;
  logic [31:0]  pcplus4f;
  logic         misf;
  logic         bubble;

  // Sequential successor wraps modulo 2^32; a redirect is misaligned if either low bit is set.
  always_comb begin
    pcplus4f = PCF + 32'd4;
    misf     = PCSrcE && (PCTargetE[1:0] != 2'b00);
    bubble   = (state == TRAP) || misf || FlushD;
  end

  // Fetch FSM and PC: redirect beats stall, a misaligned redirect freezes fetch until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      PCF      <= RESET_PC;
      Trap     <= 1'b0;
      TrapAddr <= '0;
    end else begin
      case (state)
        RUN: begin
          if (misf) begin
            state    <= TRAP;
            Trap     <= 1'b1;
            TrapAddr <= PCTargetE;
          end else if (PCSrcE) begin
            PCF <= PCTargetE;
          end else if (!StallF) begin
            PCF <= pcplus4f;
          end
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // IF/ID register; trap and misaligned redirects are folded into its flush.
  if_id_reg #(
    .W            (XLEN),
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .stall       (StallD),
    .flush       (bubble),
    .instr_src   (InstrF),
    .pc_src      (PCF),
    .pcplus4_src (pcplus4f),
    .instr       (InstrD),
    .pc          (PCD),
    .pcplus4     (PCPlus4D),
    .valid       (ValidD)
  );

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios plus randomized traffic against a behavioural fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        Trap;
  logic [31:0] TrapAddr;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model of the architectural state.
  logic [31:0] m_pc;
  logic        m_trap;
  logic [31:0] m_trapaddr;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic [31:0] m_pc4d;
  logic        m_valid;

  always #5 clk = ~clk;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1235;
  endfunction

  assign InstrF = mem_word(PCF);

  if_stage dut (
    .clk       (clk),
    .reset     (reset),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .Trap      (Trap),
    .TrapAddr  (TrapAddr)
  );

  // Apply one cycle of inputs, advance the model, and return #1 after the rising edge.
  task automatic drive(input logic rst, input logic src, input logic [31:0] tgt,
                       input logic sf, input logic sd, input logic fl);
    logic mis;
    reset = rst; PCSrcE = src; PCTargetE = tgt; StallF = sf; StallD = sd; FlushD = fl;
    mis = src && (tgt % 4 != 0);
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = 32'h0; m_trap = 1'b0; m_trapaddr = 32'h0;
      m_instr = 32'h13; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
    end else begin
      if (m_trap || mis || fl) begin
        m_instr = 32'h13; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
      end else if (!sd) begin
        m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1'b1;
      end
      if (!m_trap) begin
        if (mis) begin
          m_trap = 1'b1; m_trapaddr = tgt;
        end else if (src) begin
          m_pc = tgt;
        end else if (!sf) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (PCF !== 32'h0) $display("FAIL reset_pcf got %h exp 00000000", PCF); else n_pass++;
    n_checks++; if (InstrD !== 32'h13) $display("FAIL reset_instrd got %h exp 00000013", InstrD); else n_pass++;
    n_checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) $display("FAIL reset_pcd got %h/%h exp 0/0", PCD, PCPlus4D); else n_pass++;
    n_checks++; if (ValidD !== 1'b0) $display("FAIL reset_validd got %b exp 0", ValidD); else n_pass++;
    n_checks++; if (Trap !== 1'b0 || TrapAddr !== 32'h0) $display("FAIL reset_trap got %b/%h exp 0/0", Trap, TrapAddr); else n_pass++;
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (PCF !== 32'(4 * i)) $display("FAIL run_pcf[%0d] got %h exp %h", i, PCF, 32'(4 * i)); else n_pass++;
      n_checks++;
      if (PCD !== 32'(4 * (i - 1)) || InstrD !== mem_word(32'(4 * (i - 1))) || ValidD !== 1'b1 || PCPlus4D !== 32'(4 * i))
        $display("FAIL run_ifid[%0d] got pcd=%h instr=%h v=%b p4=%h exp pcd=%h", i, PCD, InstrD, ValidD, PCPlus4D, 32'(4 * (i - 1)));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (PCF !== 32'h8 || PCD !== 32'h4 || ValidD !== 1'b1)
        $display("FAIL stall_hold[%0d] got pcf=%h pcd=%h v=%b exp 8/4/1", i, PCF, PCD, ValidD);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (PCF !== 32'hC || PCD !== 32'h8) $display("FAIL stall_release got pcf=%h pcd=%h exp c/8", PCF, PCD); else n_pass++;
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (PCF !== 32'h100 || InstrD !== 32'h13 || ValidD !== 1'b0)
      $display("FAIL redirect_now got pcf=%h instr=%h v=%b exp 100/13/0", PCF, InstrD, ValidD);
    else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (PCF !== 32'h104 || InstrD !== mem_word(32'h100) || PCD !== 32'h100 || ValidD !== 1'b1)
      $display("FAIL redirect_next got pcf=%h instr=%h pcd=%h v=%b exp 104/%h/100/1", PCF, InstrD, PCD, ValidD, mem_word(32'h100));
    else n_pass++;
  endtask

  task automatic test_flush_stall();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (ValidD !== 1'b0 || InstrD !== 32'h13 || PCD !== 32'h0)
      $display("FAIL flush_over_stall got v=%b instr=%h pcd=%h exp 0/13/0", ValidD, InstrD, PCD);
    else n_pass++;
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (PCF !== 32'h0 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0)
      $display("FAIL wrap got pcf=%h pcd=%h p4=%h exp 0/fffffffc/0", PCF, PCD, PCPlus4D);
    else n_pass++;
  endtask

  task automatic test_trap();
    logic [31:0] frozen;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    frozen = m_pc;
    drive(1'b0, 1'b1, 32'h102, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (Trap !== 1'b1 || TrapAddr !== 32'h102 || PCF !== frozen || ValidD !== 1'b0)
      $display("FAIL trap_entry got trap=%b addr=%h pcf=%h v=%b exp 1/102/%h/0", Trap, TrapAddr, PCF, ValidD, frozen);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, i[0], 32'h200, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (Trap !== 1'b1 || TrapAddr !== 32'h102 || PCF !== frozen || ValidD !== 1'b0)
        $display("FAIL trap_hold[%0d] got trap=%b addr=%h pcf=%h v=%b", i, Trap, TrapAddr, PCF, ValidD);
      else n_pass++;
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (PCF !== 32'h0 || Trap !== 1'b0 || TrapAddr !== 32'h0 || ValidD !== 1'b0)
      $display("FAIL trap_reset got pcf=%h trap=%b addr=%h v=%b exp 0/0/0/0", PCF, Trap, TrapAddr, ValidD);
    else n_pass++;
  endtask

  task automatic test_random();
    logic        rst, src, sf, sd, fl;
    logic [31:0] tgt;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      src = ($urandom_range(0, 5) == 0);
      tgt = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 24) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      sf = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 5) == 0);
      drive(rst, src, tgt, sf, sd, fl);
      n_checks++;
      if (PCF !== m_pc || Trap !== m_trap || TrapAddr !== m_trapaddr)
        $display("FAIL rand_fetch[%0d] got pcf=%h trap=%b addr=%h exp %h/%b/%h", i, PCF, Trap, TrapAddr, m_pc, m_trap, m_trapaddr);
      else n_pass++;
      n_checks++;
      if (InstrD !== m_instr || PCD !== m_pcd || PCPlus4D !== m_pc4d || ValidD !== m_valid)
        $display("FAIL rand_ifid[%0d] got %h/%h/%h/%b exp %h/%h/%h/%b", i, InstrD, PCD, PCPlus4D, ValidD, m_instr, m_pcd, m_pc4d, m_valid);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'h0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    m_pc = 32'h0; m_trap = 1'b0; m_trapaddr = 32'h0;
    m_instr = 32'h13; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_wrap();
    test_trap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
